// File: rtl/renode_ahb_arbiter.sv
// renode_ahb_arbiter: AHB-Lite arbiter that lets 2..4 managers share one subordinate.
// The address phase comes from addr_owner and the write data from data_owner.
// Ownership moves only while the current owner presents IDLE.
// Ports:
//   HCLK, HRESETn                        clock, async active-low reset
//   m_HTRANS/HADDR/HWRITE/HSIZE/HBURST   per-manager address-phase request
//   m_HWDATA                             per-manager write data
//   m_HREADY, m_HRESP                    per-manager ready/stall and response
//   m_HRDATA                             read data, broadcast to all managers
//   s_*                                  subordinate-side AHB-Lite bus
//   grant                                one-hot address-phase owner (debug)
module renode_ahb_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_MANAGERS = 2
) (
  input  logic                                    HCLK,
  input  logic                                    HRESETn,
  input  logic [NUM_MANAGERS-1:0][1:0]            m_HTRANS,
  input  logic [NUM_MANAGERS-1:0][ADDR_WIDTH-1:0] m_HADDR,
  input  logic [NUM_MANAGERS-1:0]                 m_HWRITE,
  input  logic [NUM_MANAGERS-1:0][2:0]            m_HSIZE,
  input  logic [NUM_MANAGERS-1:0][2:0]            m_HBURST,
  input  logic [NUM_MANAGERS-1:0][DATA_WIDTH-1:0] m_HWDATA,
  output logic [NUM_MANAGERS-1:0]                 m_HREADY,
  output logic [NUM_MANAGERS-1:0]                 m_HRESP,
  output logic [DATA_WIDTH-1:0]                   m_HRDATA,
  output logic [1:0]                              s_HTRANS,
  output logic [ADDR_WIDTH-1:0]                   s_HADDR,
  output logic                                    s_HWRITE,
  output logic [2:0]                              s_HSIZE,
  output logic [2:0]                              s_HBURST,
  output logic [DATA_WIDTH-1:0]                   s_HWDATA,
  input  logic                                    s_HREADYOUT,
  input  logic                                    s_HRESP,
  input  logic [DATA_WIDTH-1:0]                   s_HRDATA,
  output logic                                    s_HREADY,
  output logic [NUM_MANAGERS-1:0]                 grant
);

  localparam int unsigned IDX_W = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;

  logic [IDX_W-1:0] addr_owner_q, addr_owner_d;
  logic [IDX_W-1:0] data_owner_q, data_owner_d;
  logic [IDX_W-1:0] rr_last_q,    rr_last_d;
  logic             data_active_q, data_active_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Ownership state; reset acts immediately and discards in-flight transfers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner_q  <= '0;
      data_owner_q  <= '0;
      data_active_q <= 1'b0;
      rr_last_q     <= IDX_W'(NUM_MANAGERS - 1);
    end else begin
      addr_owner_q  <= addr_owner_d;
      data_owner_q  <= data_owner_d;
      data_active_q <= data_active_d;
      rr_last_q     <= rr_last_d;
    end
  end

  // Phase tracking and round-robin re-arbitration at idle boundaries
  always_comb begin
    addr_owner_d  = addr_owner_q;
    data_owner_d  = data_owner_q;
    data_active_d = data_active_q;
    rr_last_d     = rr_last_q;
    cand          = addr_owner_q;
    found         = 1'b0;
    if (s_HREADYOUT) begin
      data_active_d = s_HTRANS[1];
      data_owner_d  = addr_owner_q;
      if (m_HTRANS[addr_owner_q] == 2'b00) begin
        // Owner itself is IDLE, so scanning the other N-1 indices is enough
        for (int unsigned k = 1; k < NUM_MANAGERS; k++) begin
          cand = IDX_W'((32'(addr_owner_q) + k) % NUM_MANAGERS);
          if (!found && m_HTRANS[cand][1]) begin
            found        = 1'b1;
            addr_owner_d = cand;
            rr_last_d    = cand;
          end
        end
      end
    end
  end

  // Subordinate-side request mux; HTRANS forced to IDLE while in reset
  always_comb begin
    s_HTRANS = HRESETn ? m_HTRANS[addr_owner_q] : 2'b00;
    s_HADDR  = m_HADDR[addr_owner_q];
    s_HWRITE = m_HWRITE[addr_owner_q];
    s_HSIZE  = m_HSIZE[addr_owner_q];
    s_HBURST = m_HBURST[addr_owner_q];
    s_HWDATA = m_HWDATA[data_owner_q];
    s_HREADY = s_HREADYOUT;
    m_HRDATA = s_HRDATA;
  end

  // Per-manager ready/response: non-owners stall only while requesting
  always_comb begin
    m_HREADY = '0;
    m_HRESP  = '0;
    grant    = '0;
    grant[addr_owner_q] = 1'b1;
    for (int unsigned i = 0; i < NUM_MANAGERS; i++) begin
      if (IDX_W'(i) == addr_owner_q) begin
        m_HREADY[i] = s_HREADYOUT;
      end else begin
        m_HREADY[i] = ~m_HTRANS[i][1];
      end
      m_HRESP[i] = data_active_q && (IDX_W'(i) == data_owner_q) && s_HRESP;
    end
  end

endmodule

// File: doc/renode_ahb_arbiter.md
# renode_ahb_arbiter

Two-to-four-way AHB-Lite arbiter that lets several AHB managers (e.g. several Renode-driven manager instances, or a Renode manager plus an RTL DMA) share one subordinate-side AHB-Lite bus. It tracks address-phase and data-phase ownership separately. It stalls non-granted managers via their private HREADY and routes response signals only to the data-phase owner. Grant changes only at idle boundaries, so no transfer is ever split or dropped.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width
- NUM_MANAGERS, 2, requester count, legal 2..4
- HCLK  in  1  bus clock
- HRESETn  in  1  reset, asynchronous, active-low
- m_HTRANS  in  [NUM_MANAGERS][2]  per-manager transfer type
- m_HADDR  in  [NUM_MANAGERS][ADDR_WIDTH]  per-manager address
- m_HWRITE  in  [NUM_MANAGERS]  per-manager direction
- m_HSIZE  in  [NUM_MANAGERS][3]  per-manager size
- m_HBURST  in  [NUM_MANAGERS][3]  per-manager burst
- m_HWDATA  in  [NUM_MANAGERS][DATA_WIDTH]  per-manager write data
- m_HREADY  out  [NUM_MANAGERS]  per-manager ready/stall
- m_HRESP  out  [NUM_MANAGERS]  per-manager response
- m_HRDATA  out  [DATA_WIDTH]  read data, broadcast to all managers
- s_HTRANS, s_HADDR, s_HWRITE, s_HSIZE, s_HBURST, s_HWDATA  out  as above  forwarded subordinate request
- s_HREADYOUT  in  1  subordinate ready
- s_HRESP  in  1  subordinate response
- s_HRDATA  in  [DATA_WIDTH]  subordinate read data
- s_HREADY  out  1  equals s_HREADYOUT, combinational
- grant  out  [NUM_MANAGERS]  one-hot address-phase owner, debug

## Operation
- State registers:
  - addr_owner (index), reset 0
  - data_active (1 b), reset 0
  - data_owner (index), reset 0
  - rr_last (index), reset NUM_MANAGERS-1
- Request: m_HTRANS[i] is NONSEQ(2) or SEQ(3). IDLE(0) or BUSY(1) is no request.
- Address mux: all s_ request outputs come from addr_owner. During reset, s_HTRANS is forced to 0.
- Data mux: s_HWDATA comes from data_owner.
- data_active is updated only when s_HREADYOUT=1: data_active <= s_HTRANS[1], data_owner <= addr_owner.
- m_HREADY[i]:
  - i==addr_owner: s_HREADYOUT.
  - Otherwise: 1 if m_HTRANS[i] is IDLE or BUSY, else 0 (stall; the manager holds its address per AHB).
- m_HRESP[i]: s_HRESP if data_active and i==data_owner, else 0.
- Arbitration condition: s_HREADYOUT=1 and m_HTRANS[addr_owner]==IDLE.
  - Scan round-robin starting at addr_owner+1 (mod NUM_MANAGERS) and select the first requester.
  - If one is found: addr_owner and rr_last <= that index.
  - If none is found: addr_owner is unchanged (parking on last owner).
- A switch happens only while the owner presents IDLE. The outgoing owner therefore has no data phase left after the switch, and a non-owner never has an outstanding data phase.
- The owner keeps the grant across back-to-back NONSEQ/SEQ and across BUSY. Fairness relies on managers returning to IDLE; the single-transfer Renode managers do so after every transfer.
- ERROR response: the owner sees both HRESP cycles. Its mandatory IDLE after the error permits a switch.

## Timing
- No added latency for the owner: address and data phases pass through combinationally.
- A non-owner that raises NONSEQ waits at least:
  - 1 cycle for the arbitration edge (owner IDLE with s_HREADYOUT=1), then
  - its own address phase in the next cycle.
  - Minimum: 1 stall cycle, m_HREADY=0.
- Wait states: s_HREADYOUT=0 freezes addr_owner, data_owner and data_active. Only the owner's m_HREADY follows it.
- Simultaneous requests from all managers with owner idle: the index closest after addr_owner wins.
- Reset asserted mid-transfer, asynchronous:
  - All state returns to reset values immediately.
  - s_HTRANS=0 immediately.
  - m_HRESP=0, grant=1<<0.
  - In-flight transfers are discarded.
- Reset release: first grant evaluation happens at the first HCLK edge with HRESETn=1.

## Test plan
- Reset: hold HRESETn=0 with m_HTRANS[1]=2 -> s_HTRANS=0, grant=01, m_HRESP=00, m_HREADY[1]=0 after release until granted.
- Single owner write: m0 NONSEQ write 0x1000, data 0xA5A5A5A5, zero-wait subordinate -> s_HADDR=0x1000 same cycle, s_HWDATA=0xA5A5A5A5 next cycle, m_HREADY[0]=1 throughout.
- Contention: m0 and m1 NONSEQ in the same cycle, owner m0 -> m0 read of 0x2000 completes first; m_HREADY[1]=0 until m0 returns IDLE; m1 address 0x3000 appears on s_HADDR exactly one cycle after m0's IDLE is accepted.
- Round-robin with NUM_MANAGERS=3: all three request continuously, each going IDLE after one transfer -> grant order 0,1,2,0.
- Wait states and error: subordinate inserts 2 cycles of s_HREADYOUT=0, then a 2-cycle ERROR for m1 -> only m_HREADY[1] follows the stalls; m_HRESP[1]=1 for both cycles; m_HRESP[0]=0.
- Reset mid-transfer: HRESETn drops during m1's data phase with s_HREADYOUT=0 -> s_HTRANS=0 and grant=01 with no clock edge; the next transfer after release is handled normally.
